apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 126 ++++++++++++
 tb/tb_apb_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: one command at a time through IDLE -> SETUP -> ACCESS; APB_MASTER_TIMEOUT_EN adds a stalled-ACCESS abort.
// Latency: 3 cycles from accept to rsp_valid, plus one cycle per PREADY wait state; rsp_valid is a one-cycle pulse.
// Backpressure: cmd_ready is high only in IDLE, commands are never queued, and the response cannot be stalled.
module apb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        cmd_ready_d, psel_d, penable_d, pwrite_d, rsp_valid_d;
  logic [31:0] paddr_d, pwdata_d, rsp_rdata_d;
  logic        timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_q;

  // The edge that would be the TIMEOUT_CYCLES-th stalled ACCESS cycle aborts instead.
  assign timeout_hit = (state_q == ACCESS) && !PREADY &&
                       (tmo_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tmo_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= timeout_hit;
      if (state_q != ACCESS) tmo_q <= '0;
      else if (!PREADY)      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same edge.
        if (PREADY || timeout_hit) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (PREADY && !PWRITE) ? PRDATA : 32'h0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 32'h0;
      PWDATA    <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: scoreboard of expected responses, one task per scenario.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  apb_master #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic push_exp(input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  // Slave model and monitor. Starts at a negedge in SETUP, answers PREADY after
  // 'waits' stalled ACCESS cycles, returns at the negedge where rsp_valid is seen.
  task automatic run_xfer(input int waits, input logic [31:0] rdata,
                          output int n_setup, output int n_access, output bit got,
                          output logic [31:0] rd, output logic er,
                          output bit rdy_low, output bit stable);
    logic [31:0] a0, d0;
    logic        w0;
    int          guard;
    n_setup = 0; n_access = 0; got = 0; rd = '0; er = 1'b0;
    rdy_low = 1; stable = 1; guard = 0;
    a0 = PADDR; d0 = PWDATA; w0 = PWRITE;
    PREADY = 1'b0;
    while (!got && guard < 200) begin
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; er = rsp_err;
      end else begin
        if (cmd_ready) rdy_low = 0;
        if (PADDR !== a0 || PWDATA !== d0 || PWRITE !== w0) stable = 0;
        if (PSEL && !PENABLE) n_setup++;
        if (PSEL && PENABLE) begin
          n_access++;
          if (n_access > waits) begin PREADY = 1'b1; PRDATA = rdata; end
          else begin PREADY = 1'b0; PRDATA = $urandom; end
        end
        @(negedge PCLK);
        guard++;
      end
    end
    PREADY = 1'b0;
  endtask

  task automatic test_reset;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    repeat (2) @(negedge PCLK);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b exp=000", {PSEL, PENABLE, PWRITE}); end
    total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0) begin bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", PADDR, PWDATA); end
    total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got=%b%b exp=00", rsp_valid, rsp_err); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    PRESET = 1'b0;
    @(negedge PCLK);
    total++; if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin bad++; $display("FAIL post_reset_idle got rdy=%b psel=%b exp 1/0", cmd_ready, PSEL); end
  endtask

  task automatic test_write;
    int ns, na; bit got, rl, st; logic [31:0] rd; logic er; exp_t e;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'hDEADBEEF;
    push_exp(32'h0, 1'b0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin bad++; $display("FAIL wr_setup_ctrl got=%b exp=101", {PSEL, PENABLE, PWRITE}); end
    total++; if (PADDR !== 32'h4 || PWDATA !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_setup_bus got=%h/%h exp=4/deadbeef", PADDR, PWDATA); end
    run_xfer(0, 32'hAAAA5555, ns, na, got, rd, er, rl, st);
    total++; if (!got) begin bad++; $display("FAIL wr_rsp got=none exp=rsp_valid"); end
    total++; if (ns !== 1 || na !== 1) begin bad++; $display("FAIL wr_phases got setup=%0d access=%0d exp=1/1", ns, na); end
    total++; if (!rl || !st) begin bad++; $display("FAIL wr_ready_stable got rdy_low=%0d stable=%0d exp=1/1", rl, st); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL wr_rsp_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_done_idle got=%b%b%b exp=001", PSEL, PENABLE, cmd_ready); end
    @(negedge PCLK);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse_len got=%b exp=0", rsp_valid); end
    total++; if (PADDR !== 32'h4 || PWDATA !== 32'hDEADBEEF || PWRITE !== 1'b1) begin bad++; $display("FAIL wr_idle_hold got=%h/%h/%b exp=4/deadbeef/1", PADDR, PWDATA, PWRITE); end
  endtask

  task automatic test_read_wait;
    int ns, na; bit got, rl, st; logic [31:0] rd; logic er; exp_t e; bit held;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = 32'h11111111;
    push_exp(32'h12345678, 1'b0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    total++; if (PWRITE !== 1'b0 || PADDR !== 32'h8) begin bad++; $display("FAIL rd_setup got=%b/%h exp=0/8", PWRITE, PADDR); end
    run_xfer(3, 32'h12345678, ns, na, got, rd, er, rl, st);
    total++; if (!got || na !== 4) begin bad++; $display("FAIL rd_wait_access got rsp=%0d access=%0d exp=1/4", got, na); end
    total++; if (!rl || !st) begin bad++; $display("FAIL rd_ready_stable got=%0d/%0d exp=1/1", rl, st); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL rd_rsp_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    held = 1;
    for (int i = 0; i < 4; i++) begin
      PRDATA = $urandom;
      @(negedge PCLK);
      if (rsp_rdata !== 32'h12345678 || rsp_valid !== 1'b0) held = 0;
    end
    total++; if (!held) begin bad++; $display("FAIL rd_rdata_hold got=%h exp=12345678", rsp_rdata); end
  endtask

  task automatic test_back_to_back;
    int ns, na; bit got, rl, st; logic [31:0] rd; logic er; exp_t e;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h0;
    push_exp(32'hA5A5F00D, 1'b0);
    @(negedge PCLK);
    // Second command is presented while the first is in flight and must be ignored.
    cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'h55AA55AA;
    run_xfer(1, 32'hA5A5F00D, ns, na, got, rd, er, rl, st);
    total++; if (!got || !rl || !st || na !== 2) begin bad++; $display("FAIL b2b_first got rsp=%0d rdy_low=%0d stable=%0d access=%0d exp=1/1/1/2", got, rl, st, na); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL b2b_first_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_accept_on_rsp got=%b exp=1", cmd_ready); end
    push_exp(32'h0, 1'b0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h14) begin bad++; $display("FAIL b2b_second_setup got=%b/%h exp=101/14", {PSEL, PENABLE, PWRITE}, PADDR); end
    run_xfer(0, 32'hFFFFFFFF, ns, na, got, rd, er, rl, st);
    total++; if (!got || !rl || ns !== 1 || na !== 1) begin bad++; $display("FAIL b2b_second got rsp=%0d rdy_low=%0d setup=%0d access=%0d exp=1/1/1/1", got, rl, ns, na); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL b2b_second_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    @(negedge PCLK);
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int ns, na; bit got, rl, st; logic [31:0] rd; logic er; exp_t e;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
    push_exp(32'h0, 1'b1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    run_xfer(1000, 32'h0, ns, na, got, rd, er, rl, st);
    total++; if (!got || na !== 16) begin bad++; $display("FAIL tmo_abort got rsp=%0d access=%0d exp=1/16", got, na); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL tmo_abort_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    total++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%b%b exp=00", PSEL, PENABLE); end
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_addr = 32'h44;
    push_exp(32'hCAFEF00D, 1'b0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    run_xfer(15, 32'hCAFEF00D, ns, na, got, rd, er, rl, st);
    total++; if (!got || na !== 16) begin bad++; $display("FAIL tmo_ready_wins got rsp=%0d access=%0d exp=1/16", got, na); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL tmo_ready_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    @(negedge PCLK);
  endtask
`else
  task automatic test_no_timeout;
    int ns, na; bit got, rl, st; logic [31:0] rd; logic er; exp_t e;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_wdata = 32'h0;
    push_exp(32'h0BADC0DE, 1'b0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    run_xfer(40, 32'h0BADC0DE, ns, na, got, rd, er, rl, st);
    total++; if (!got || na !== 41) begin bad++; $display("FAIL long_wait got rsp=%0d access=%0d exp=1/41", got, na); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL long_wait_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    @(negedge PCLK);
  endtask
`endif

  task automatic test_reset_mid;
    int ns, na; bit got, rl, st; logic [31:0] rd; logic er; exp_t e; bit quiet;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h77777777;
    PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    total++; if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin bad++; $display("FAIL rstmid_in_access got=%b%b exp=11", PSEL, PENABLE); end
    #2 PRESET = 1'b1;
    #1;
    total++; if ({cmd_ready, PSEL, PENABLE, PWRITE} !== 4'b1000) begin bad++; $display("FAIL rstmid_async_ctrl got=%b exp=1000", {cmd_ready, PSEL, PENABLE, PWRITE}); end
    total++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async_data got=%h/%h/%h/%b exp=0/0/0/0", PADDR, PWDATA, rsp_rdata, rsp_valid); end
    @(negedge PCLK);
    PRESET = 1'b0;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      PREADY = 1'b1;
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) quiet = 0;
    end
    PREADY = 1'b0;
    total++; if (!quiet) begin bad++; $display("FAIL rstmid_no_rsp got rsp_valid=%b exp=0", rsp_valid); end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = 32'h0;
    push_exp(32'h0F0F0F0F, 1'b0);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    run_xfer(2, 32'h0F0F0F0F, ns, na, got, rd, er, rl, st);
    total++; if (!got || ns !== 1 || na !== 3) begin bad++; $display("FAIL rstmid_next got rsp=%0d setup=%0d access=%0d exp=1/1/3", got, ns, na); end
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL rstmid_next_data got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err); end
    end
    @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
